// File: rtl/sevenseg_decoder.sv
// Receive-side decoder for a two-digit seven-segment display: synchronizes, filters and decodes to 0-99.
// Optional SEVENSEG_DECODER_STATS_EN adds saturating accept/error counters.
module sevenseg_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        S1_A,
  input  logic        S1_B,
  input  logic        S1_C,
  input  logic        S1_D,
  input  logic        S1_E,
  input  logic        S1_F,
  input  logic        S1_G,
  input  logic        S2_A,
  input  logic        S2_B,
  input  logic        S2_C,
  input  logic        S2_D,
  input  logic        S2_E,
  input  logic        S2_F,
  input  logic        S2_G,
  output logic [7:0]  value,
  output logic        value_valid,
  output logic        blank,
  output logic        decode_err
`ifdef SEVENSEG_DECODER_STATS_EN
  ,
  output logic [15:0] accept_count,
  output logic [15:0] err_count
`endif
);

  localparam logic [13:0] UNLIT_PINS  = ACTIVE_LOW ? 14'h3FFF : 14'h0000;
  localparam logic [7:0]  STABLE_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0]  STABLE_LAST = 8'(STABLE_CYCLES - 1);

  typedef struct packed {
    logic       legal;
    logic       is_blank;
    logic [3:0] digit;
  } digit_t;

  function automatic digit_t decode_digit(input logic [6:0] seg);
    digit_t d;
    d.legal    = 1'b1;
    d.is_blank = 1'b0;
    d.digit    = 4'd0;
    case (seg)
      7'b0111111: d.digit = 4'd0;
      7'b0000110: d.digit = 4'd1;
      7'b1011011: d.digit = 4'd2;
      7'b1001111: d.digit = 4'd3;
      7'b1100110: d.digit = 4'd4;
      7'b1101101: d.digit = 4'd5;
      7'b1111101: d.digit = 4'd6;
      7'b0000111: d.digit = 4'd7;
      7'b1111111: d.digit = 4'd8;
      7'b1101111: d.digit = 4'd9;
      7'b0000000: begin
        d.legal    = 1'b0;
        d.is_blank = 1'b1;
      end
      default:    d.legal = 1'b0;
    endcase
    return d;
  endfunction

  logic [13:0] pins;
  logic [13:0] s1;
  logic [13:0] s2;
  logic [13:0] acc;
  logic [13:0] lit;
  logic [7:0]  cnt;
  logic        same;
  logic        accept;
  logic        valid_next;
  logic        err_next;
  logic        blank_set;
  digit_t      tens;
  digit_t      units;
  logic [7:0]  tens_ext;
  logic [7:0]  units_ext;
  logic [7:0]  value_next;

  assign pins = {S1_G, S1_F, S1_E, S1_D, S1_C, S1_B, S1_A,
                 S2_G, S2_F, S2_E, S2_D, S2_C, S2_B, S2_A};

  assign lit       = ACTIVE_LOW ? ~s2 : s2;
  assign tens      = decode_digit(lit[13:7]);
  assign units     = decode_digit(lit[6:0]);
  assign tens_ext  = {4'b0000, tens.digit};
  assign units_ext = {4'b0000, units.digit};

  // s1 holds the value s2 takes on this edge, so comparing them detects an s2 change one edge early.
  assign same   = (s1 == s2);
  assign accept = same && (cnt == STABLE_LAST) && (s2 != acc);

  always_comb begin
    valid_next = 1'b0;
    err_next   = 1'b0;
    blank_set  = 1'b0;
    value_next = value;
    if (accept) begin
      if (units.legal && tens.legal) begin
        valid_next = 1'b1;
        value_next = (tens_ext << 3) + (tens_ext << 1) + units_ext;
      end else if (units.legal && tens.is_blank) begin
        valid_next = 1'b1;
        value_next = units_ext;
      end else if (units.is_blank && tens.is_blank) begin
        blank_set = 1'b1;
      end else begin
        err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= UNLIT_PINS;
      s2          <= UNLIT_PINS;
      acc         <= UNLIT_PINS;
      cnt         <= 8'd0;
      value       <= 8'd0;
      value_valid <= 1'b0;
      decode_err  <= 1'b0;
      blank       <= 1'b1;
    end else begin
      s1          <= pins;
      s2          <= s1;
      value_valid <= valid_next;
      decode_err  <= err_next;
      value       <= value_next;
      if (!same) begin
        cnt <= 8'd0;
      end else if (cnt < STABLE_MAX) begin
        cnt <= cnt + 8'd1;
      end
      if (accept) begin
        acc <= s2;
      end
      if (valid_next) begin
        blank <= 1'b0;
      end else if (blank_set) begin
        blank <= 1'b1;
      end
    end
  end

`ifdef SEVENSEG_DECODER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      accept_count <= 16'd0;
      err_count    <= 16'd0;
    end else begin
      if (valid_next && (accept_count != 16'hFFFF)) begin
        accept_count <= accept_count + 16'd1;
      end
      if (err_next && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'd1;
      end
    end
  end
`endif

endmodule
